// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns one pipeline load/store into one or two
// word-aligned bus beats, handling misaligned accesses that straddle a word
// boundary. Load data is realigned and sign/zero-extended.
module lsu_bus_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_strb,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_live;       // low during reset; keeps ready low until first edge after release
    logic        r_we;
    logic        r_err;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [29:0] r_word;       // word index of the first beat
    logic [7:0]  r_strb8;
    logic [63:0] r_wdata64;
    logic [31:0] r_lo;
    logic [31:0] r_hi;

    logic        w_accept;
    logic        w_legal;
    logic        w_split;
    logic [3:0]  w_mask;
    logic [7:0]  w_strb8;
    logic [63:0] w_wdata64;
    logic [31:0] w_shift;
    logic [31:0] w_load_data;

    assign o_req_ready = (r_state == S_IDLE) && r_live;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_split     = |r_strb8[7:4];

    // Legality and lane placement of the incoming request.
    always_comb begin
        if (i_req_we)
            w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
        else
            w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010)
                   || (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
        case (i_funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
        w_strb8   = {4'b0000, w_mask} << i_addr[1:0];
        w_wdata64 = {32'd0, i_wdata} << {i_addr[1:0], 3'b000};
    end

    // Realign the captured {high, low} words and extend to 32 bits.
    always_comb begin
        w_shift = 32'({r_hi, r_lo} >> {r_off, 3'b000});
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_data = {24'd0, w_shift[7:0]};
            3'b101:  w_load_data = {16'd0, w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
        end
    end

    // Request capture and beat read-data capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_funct3  <= 3'd0;
            r_off     <= 2'd0;
            r_word    <= 30'd0;
            r_strb8   <= 8'd0;
            r_wdata64 <= 64'd0;
            r_lo      <= 32'd0;
            r_hi      <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we      <= i_req_we;
                r_err     <= !w_legal;
                r_funct3  <= i_funct3;
                r_off     <= i_addr[1:0];
                r_word    <= i_addr[31:2];
                r_strb8   <= w_strb8;
                r_wdata64 <= w_wdata64;
                r_lo      <= 32'd0;
                r_hi      <= 32'd0;   // unsplit accesses see a zero high word
            end
            if (r_state == S_WAIT0 && i_mem_rvalid)
                r_lo <= i_mem_rdata;
            if (r_state == S_WAIT1 && i_mem_rvalid)
                r_hi <= i_mem_rdata;
        end
    end

    // Next-state and output decode; bus outputs are zero whenever no beat is requested.
    always_comb begin
        w_state_next = r_state;
        o_mem_req    = 1'b0;
        o_mem_addr   = 32'd0;
        o_mem_we     = 1'b0;
        o_mem_wdata  = 32'd0;
        o_mem_strb   = 4'd0;
        o_rsp_valid  = 1'b0;
        o_rsp_err    = 1'b0;
        o_rsp_rdata  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_next = w_legal ? S_REQ0 : S_RESP;
            end
            S_REQ0: begin
                o_mem_req   = 1'b1;
                o_mem_addr  = {r_word, 2'b00};
                o_mem_we    = r_we;
                o_mem_wdata = r_wdata64[31:0];
                o_mem_strb  = r_strb8[3:0];
                if (i_mem_gnt)
                    w_state_next = S_WAIT0;
            end
            S_WAIT0: begin
                if (i_mem_rvalid)
                    w_state_next = w_split ? S_REQ1 : S_RESP;
            end
            S_REQ1: begin
                o_mem_req   = 1'b1;
                o_mem_addr  = {r_word + 30'd1, 2'b00};   // wraps past the top of memory
                o_mem_we    = r_we;
                o_mem_wdata = r_wdata64[63:32];
                o_mem_strb  = r_strb8[7:4];
                if (i_mem_gnt)
                    w_state_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (i_mem_rvalid)
                    w_state_next = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid  = 1'b1;
                o_rsp_err    = r_err;
                if (!r_err && !r_we)
                    o_rsp_rdata = w_load_data;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
